// File: rtl/run_scan_pkg.sv
// Shared state type and default sizing for the serial run-scan controller.
package run_scan_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} scan_state_t;

   localparam int unsigned NBITS_DEF   = 8;
   localparam int unsigned RUN_LEN_DEF = 3;

endpackage

// File: rtl/run_detector.sv
// Serial run detector: flags every bit that completes a run of RUN_LEN or more ones.
module run_detector #(
   parameter int unsigned RUN_LEN = 3
) (
   input  logic clk_2,
   input  logic reset,
   input  logic clear,
   input  logic in_bit,
   output logic detect
);

   localparam int unsigned RW = $clog2(RUN_LEN + 1);

   logic [RW-1:0] cnt_q, cnt_d;

   // Saturating count lets detect stay high across runs longer than RUN_LEN.
   always_comb begin
      cnt_d = cnt_q;
      if (clear || !in_bit) begin
         cnt_d = '0;
      end else if (cnt_q != RW'(RUN_LEN)) begin
         cnt_d = cnt_q + RW'(1);
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign detect = (cnt_q == RW'(RUN_LEN));

endmodule

// File: rtl/run_scan_ctrl.sv
// Latches a word, shifts it MSB-first through the run detector, and reports hit count,
// first-hit position and a one-cycle done pulse.
module run_scan_ctrl
   import run_scan_pkg::*;
#(
   parameter int unsigned NBITS   = NBITS_DEF,
   parameter int unsigned RUN_LEN = RUN_LEN_DEF,
   localparam int unsigned CW     = $clog2(NBITS + 1),
   localparam int unsigned PW     = $clog2(NBITS)
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic             start,
   input  logic [NBITS-1:0] word_in,
   output logic             busy,
   output logic             done,
   output logic             in_bit,
   output logic             detect,
   output logic [CW-1:0]    hit_count,
   output logic             any_hit,
   output logic [PW-1:0]    first_hit_pos
);

   scan_state_t      state_q, state_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0]    hit_count_q, hit_count_d;
   logic [PW-1:0]    first_q, first_d;
   logic             det_clear;

   run_detector #(
      .RUN_LEN (RUN_LEN)
   ) u_det (
      .clk_2  (clk_2),
      .reset  (reset),
      .clear  (det_clear),
      .in_bit (in_bit),
      .detect (detect)
   );

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_idx_d   = bit_idx_q;
      hit_count_d = hit_count_q;
      first_d     = first_q;
      det_clear   = 1'b0;

      unique case (state_q)
         IDLE: begin
            det_clear = 1'b1;
            if (start) begin
               shreg_d     = word_in;
               bit_idx_d   = '0;
               hit_count_d = '0;
               first_d     = '0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d   = {shreg_q[NBITS-2:0], 1'b0};
            bit_idx_d = bit_idx_q + CW'(1);
            if (bit_idx_q == CW'(NBITS - 1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // detect lags in_bit by one clock, so it belongs to bit (bit_idx_q - 1).
      if ((((state_q == SHIFT) && (bit_idx_q != '0)) || (state_q == DRAIN)) && detect) begin
         if (hit_count_q == '0) begin
            first_d = PW'(bit_idx_q - CW'(1));
         end
         hit_count_d = hit_count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bit_idx_q   <= '0;
         hit_count_q <= '0;
         first_q     <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_idx_q   <= bit_idx_d;
         hit_count_q <= hit_count_d;
         first_q     <= first_d;
      end
   end

   always_comb begin
      busy          = (state_q == SHIFT) || (state_q == DRAIN);
      done          = (state_q == DONE);
      in_bit        = (state_q == SHIFT) ? shreg_q[NBITS-1] : 1'b0;
      any_hit       = (hit_count_q != '0);
      hit_count     = hit_count_q;
      first_hit_pos = first_q;
   end

endmodule

// File: tb/tb_run_scan_ctrl.sv
// Bench for run_scan_ctrl: per-cycle comparison against a run-of-ones model, plus directed scans.
module tb_run_scan_ctrl;

   localparam int NB = 8;

   logic       clk_2   = 1'b0;
   logic       reset   = 1'b1;
   logic       start   = 1'b0;
   logic [7:0] word_in = 8'h00;

   logic       busy, done, in_bit, detect, any_hit;
   logic [3:0] hit_count;
   logic [2:0] first_hit_pos;
   logic       busy2, done2, in_bit2, detect2, any_hit2;
   logic [3:0] hit_count2;
   logic [2:0] first_hit_pos2;

   int checks = 0;
   int passes = 0;

   run_scan_ctrl #(.NBITS(8), .RUN_LEN(3)) u_dut (
      .clk_2(clk_2), .reset(reset), .start(start), .word_in(word_in),
      .busy(busy), .done(done), .in_bit(in_bit), .detect(detect),
      .hit_count(hit_count), .any_hit(any_hit), .first_hit_pos(first_hit_pos)
   );

   run_scan_ctrl #(.NBITS(8), .RUN_LEN(2)) u_dut2 (
      .clk_2(clk_2), .reset(reset), .start(start), .word_in(word_in),
      .busy(busy2), .done(done2), .in_bit(in_bit2), .detect(detect2),
      .hit_count(hit_count2), .any_hit(any_hit2), .first_hit_pos(first_hit_pos2)
   );

   always #5 clk_2 = ~clk_2;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Bit i (MSB-first) is a hit when bits i-rl+1..i are all ones.
   function automatic void scan_model(input logic [7:0] w, input int rl, output int cnt,
                                      output int first, output logic [7:0] hv);
      cnt   = 0;
      first = 0;
      hv    = '0;
      for (int i = 0; i < NB; i++) begin
         bit all1;
         all1 = (i >= rl - 1);
         for (int j = 0; j < rl; j++) begin
            if ((i - j >= 0) && !w[NB-1-(i-j)]) all1 = 1'b0;
         end
         if (all1) begin
            hv[i] = 1'b1;
            if (cnt == 0) first = i;
            cnt++;
         end
      end
   endfunction

   int         n_cnt, n_first, n_cnt2, n_first2;
   logic [7:0] n_hv, n_hv2;

   always_comb begin
      scan_model(word_in, 3, n_cnt, n_first, n_hv);
      scan_model(word_in, 2, n_cnt2, n_first2, n_hv2);
   end

   // Model phase: -1 idle, 1..NB shifting bit ph-1, NB+1 drain, NB+2 done.
   int         ph = -1;
   bit         mvalid = 1'b0;
   logic [7:0] m_word = '0;
   int         m_cnt = 0, m_first = 0, m_cnt2 = 0, m_first2 = 0;
   logic [7:0] m_hv = '0, m_hv2 = '0;

   always @(posedge clk_2) begin
      if (reset) begin
         ph       <= -1;
         m_cnt    <= 0;
         m_first  <= 0;
         m_cnt2   <= 0;
         m_first2 <= 0;
         mvalid   <= 1'b1;
      end else if (mvalid) begin
         if (ph == -1) begin
            if (start) begin
               ph       <= 1;
               m_word   <= word_in;
               m_cnt    <= n_cnt;
               m_first  <= n_first;
               m_hv     <= n_hv;
               m_cnt2   <= n_cnt2;
               m_first2 <= n_first2;
               m_hv2    <= n_hv2;
            end
         end else if (ph == NB + 2) begin
            ph <= -1;
         end else begin
            ph <= ph + 1;
         end
      end
   end

   always @(negedge clk_2) begin
      if (mvalid) begin
         chk("busy", busy, (ph >= 1 && ph <= NB + 1));
         chk("done", done, (ph == NB + 2));
         chk("in_bit", in_bit, (ph >= 1 && ph <= NB) ? m_word[NB-ph] : 1'b0);
         chk("detect", detect, (ph >= 2 && ph <= NB + 1) ? m_hv[ph-2] : 1'b0);
         chk("detect_rl2", detect2, (ph >= 2 && ph <= NB + 1) ? m_hv2[ph-2] : 1'b0);
         if (ph == -1 || ph == NB + 2) begin
            chk("hit_count", hit_count, m_cnt);
            chk("any_hit", any_hit, (m_cnt != 0));
            chk("first_hit_pos", first_hit_pos, m_first);
            chk("hit_count_rl2", hit_count2, m_cnt2);
            chk("first_hit_pos_rl2", first_hit_pos2, m_first2);
         end
      end
   end

   // Inputs change just after posedge; the following negedge observes that cycle.
   task automatic step(input logic r, input logic s, input logic [7:0] w);
      @(posedge clk_2);
      #1;
      reset   = r;
      start   = s;
      word_in = w;
      @(negedge clk_2);
   endtask

   task automatic scan_one(input string nm, input logic [7:0] w, input int eh, input int ef,
                           input int eh2, input int ef2);
      int dk, hc, fp, ah, hc2, fp2;
      dk = -1; hc = -1; fp = -1; ah = -1; hc2 = -1; fp2 = -1;
      for (int k = 0; k < 16; k++) begin
         step(1'b0, (k == 0), w);
         if (done === 1'b1 && dk < 0) begin
            dk  = k;
            hc  = hit_count;
            fp  = first_hit_pos;
            ah  = any_hit;
            hc2 = hit_count2;
            fp2 = first_hit_pos2;
         end
      end
      chk({nm, "_done_cycle"}, dk, 10);
      chk({nm, "_hits"}, hc, eh);
      chk({nm, "_first"}, fp, ef);
      chk({nm, "_any"}, ah, (eh != 0));
      chk({nm, "_hits_rl2"}, hc2, eh2);
      chk({nm, "_first_rl2"}, fp2, ef2);
      chk({nm, "_held"}, hit_count, eh);
   endtask

   initial begin
      int dq[$];
      int hq[$];
      int nd, hc, dk;

      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'hFF);
      chk("reset_busy", busy, 0);
      chk("reset_hits", hit_count, 0);
      step(1'b0, 1'b0, 8'h00);

      scan_one("ff", 8'hFF, 6, 2, 7, 1);
      scan_one("x77", 8'h77, 2, 3, 4, 2);
      scan_one("xdb", 8'hDB, 0, 0, 3, 1);

      // Start held high: second scan begins in the first idle cycle after done.
      for (int k = 0; k < 26; k++) begin
         step(1'b0, (k < 20), 8'hEE);
         if (done === 1'b1) begin
            dq.push_back(k);
            hq.push_back(hit_count);
         end
      end
      chk("ee_done_count", dq.size(), 2);
      chk("ee_done0", (dq.size() > 0) ? dq[0] : -1, 10);
      chk("ee_done1", (dq.size() > 1) ? dq[1] : -1, 21);
      chk("ee_hits0", (hq.size() > 0) ? hq[0] : -1, 2);
      chk("ee_hits1", (hq.size() > 1) ? hq[1] : -1, 2);

      // Reset in cycle 5 aborts the scan without a done pulse.
      nd = 0;
      for (int k = 0; k < 20; k++) begin
         step((k == 5), (k == 0), 8'hFF);
         if (done === 1'b1) nd++;
         if (k == 6) begin
            chk("abort_busy", busy, 0);
            chk("abort_hits", hit_count, 0);
         end
      end
      chk("abort_no_done", nd, 0);

      // Second start with a new word during shift is ignored.
      dk = -1; hc = -1;
      for (int k = 0; k < 16; k++) begin
         step(1'b0, (k == 0 || k == 3), (k == 3) ? 8'hFF : 8'h77);
         if (done === 1'b1 && dk < 0) begin
            dk = k;
            hc = hit_count;
         end
      end
      chk("ignore_done_cycle", dk, 10);
      chk("ignore_hits", hc, 2);
      chk("ignore_first", first_hit_pos, 3);

      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
      end
      step(1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
